// File: rtl/gearbox_rd_sched.sv
// gearbox_rd_sched: read-side slot scheduler between the 132b async FIFO and the 132->128 gearbox.
// Defining GB_SCHED_STATS_EN builds the frame/underrun statistics counters; otherwise they read as zero.
module gearbox_rd_sched #(
    parameter int LVL_W        = 9,
    parameter int PHASES       = 33,
    parameter int START_THRESH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_phy_ren,
    input  logic             i_fifo_empty,
    input  logic [LVL_W-1:0] i_fifo_level,
    output logic             o_fifo_ren,
    output logic             o_gb_valid,
    output logic             o_gb_flush,
    output logic [5:0]       o_phase,
    output logic             o_frame_start,
    output logic [1:0]       o_state,
    output logic             o_underrun,
    output logic [15:0]      o_frame_cnt,
    output logic [15:0]      o_underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [5:0]       LAST_PHASE = 6'(PHASES - 1);
    localparam logic [LVL_W-1:0] THRESH     = LVL_W'(START_THRESH);

    generate
        if (PHASES > 64 || PHASES < 2) begin : g_phases_chk
            $error("gearbox_rd_sched: PHASES must be in 2..64");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [5:0] phase_q, phase_d;
    logic       flush_q, flush_d;
    logic       underrun_q, underrun_d;
    logic       en_q, en_d;

    logic       active;
    logic       is_last;
    logic       slot;
    logic       urun;
    logic       fifo_ren;
    logic       gb_valid;
    logic [5:0] phase_adv;

    always_comb begin
        active    = (state_q == RUN) || (state_q == STOP);
        is_last   = (phase_q == LAST_PHASE);
        slot      = active && i_phy_ren;
        urun      = slot && !is_last && i_fifo_empty;
        fifo_ren  = slot && !is_last && !i_fifo_empty;
        gb_valid  = slot && !urun;
        phase_adv = is_last ? 6'd0 : phase_q + 6'd1;
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        flush_d    = 1'b0;
        underrun_d = underrun_q;
        en_d       = i_enable;

        if (i_enable && !en_q) begin
            underrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                phase_d = 6'd0;
                if (i_enable) begin
                    state_d = PRIME;
                    flush_d = 1'b1;
                end
            end
            PRIME: begin
                phase_d = 6'd0;
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (i_fifo_level >= THRESH) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (urun) begin
                    underrun_d = 1'b1;
                    flush_d    = 1'b1;
                    phase_d    = 6'd0;
                    state_d    = PRIME;
                end else begin
                    if (gb_valid) begin
                        phase_d = phase_adv;
                    end
                    // At phase 0 with no slot taken the gearbox holds no residue, so stop at once.
                    if (!i_enable) begin
                        state_d = (phase_q == 6'd0 && !i_phy_ren) ? IDLE : STOP;
                    end
                end
            end
            STOP: begin
                if (urun) begin
                    underrun_d = 1'b1;
                    flush_d    = 1'b1;
                    phase_d    = 6'd0;
                    state_d    = IDLE;
                end else begin
                    if (gb_valid) begin
                        phase_d = phase_adv;
                    end
                    if (i_enable) begin
                        state_d = RUN;
                    end else if (gb_valid && is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            phase_q    <= 6'd0;
            flush_q    <= 1'b0;
            underrun_q <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            flush_q    <= flush_d;
            underrun_q <= underrun_d;
            en_q       <= en_d;
        end
    end

    assign o_fifo_ren    = fifo_ren;
    assign o_gb_valid    = gb_valid;
    assign o_gb_flush    = flush_q;
    assign o_phase       = phase_q;
    assign o_frame_start = gb_valid && (phase_q == 6'd0);
    assign o_state       = state_q;
    assign o_underrun    = underrun_q;

`ifdef GB_SCHED_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] urun_cnt_q, urun_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        urun_cnt_d  = urun_cnt_q;
        if (gb_valid && is_last && frame_cnt_q != 16'hFFFF) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (urun && urun_cnt_q != 16'hFFFF) begin
            urun_cnt_d = urun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q <= 16'd0;
            urun_cnt_q  <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            urun_cnt_q  <= urun_cnt_d;
        end
    end

    assign o_frame_cnt    = frame_cnt_q;
    assign o_underrun_cnt = urun_cnt_q;
`else
    assign o_frame_cnt    = 16'h0000;
    assign o_underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gearbox_rd_sched.sv
// Testbench for gearbox_rd_sched: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_gearbox_rd_sched;

    localparam int LVL_W        = 9;
    localparam int PHASES       = 33;
    localparam int START_THRESH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             phy_ren = 1'b0;
    logic             empty = 1'b0;
    logic [LVL_W-1:0] level = '0;

    logic        o_fifo_ren, o_gb_valid, o_gb_flush, o_frame_start, o_underrun;
    logic [5:0]  o_phase;
    logic [1:0]  o_state;
    logic [15:0] o_frame_cnt, o_underrun_cnt;

    always #5 clk = ~clk;

    gearbox_rd_sched #(
        .LVL_W(LVL_W), .PHASES(PHASES), .START_THRESH(START_THRESH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_phy_ren(phy_ren),
        .i_fifo_empty(empty), .i_fifo_level(level),
        .o_fifo_ren(o_fifo_ren), .o_gb_valid(o_gb_valid), .o_gb_flush(o_gb_flush),
        .o_phase(o_phase), .o_frame_start(o_frame_start), .o_state(o_state),
        .o_underrun(o_underrun), .o_frame_cnt(o_frame_cnt), .o_underrun_cnt(o_underrun_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode uses the published o_state numbering; slot = slots consumed in current frame.
    int m_mode, m_slot, m_frames, m_uruns;
    bit m_flush, m_under, m_en_prev;

    task automatic model_reset();
        m_mode = 0; m_slot = 0; m_frames = 0; m_uruns = 0;
        m_flush = 0; m_under = 0; m_en_prev = 0;
    endtask

    function automatic logic [44:0] dut_vec();
        return {o_fifo_ren, o_gb_valid, o_gb_flush, o_phase, o_frame_start, o_state,
                o_underrun, o_frame_cnt, o_underrun_cnt};
    endfunction

    function automatic logic [44:0] exp_vec();
        bit running, lst, want, un, ren, vld, fs;
        logic [15:0] fc, uc;
        running = (m_mode == 2) || (m_mode == 3);
        lst     = (m_slot == PHASES - 1);
        want    = running && phy_ren;
        un      = want && !lst && empty;
        ren     = want && !lst && !empty;
        vld     = want && !un;
        fs      = vld && (m_slot == 0);
`ifdef GB_SCHED_STATS_EN
        fc = 16'(m_frames);
        uc = 16'(m_uruns);
`else
        fc = 16'h0;
        uc = 16'h0;
`endif
        return {ren, vld, m_flush, 6'(m_slot), fs, 2'(m_mode), m_under, fc, uc};
    endfunction

    task automatic model_clock();
        bit running, lst, want, un, vld;
        int old_slot;
        running  = (m_mode == 2) || (m_mode == 3);
        lst      = (m_slot == PHASES - 1);
        want     = running && phy_ren;
        un       = want && !lst && empty;
        vld      = want && !un;
        old_slot = m_slot;
        m_flush  = 0;
        if (en && !m_en_prev) m_under = 0;
        case (m_mode)
            0: if (en) begin m_mode = 1; m_flush = 1; end
            1: if (!en) m_mode = 0; else if (int'(level) >= START_THRESH) m_mode = 2;
            default: begin
                if (un) begin
                    m_under = 1; m_flush = 1; m_slot = 0;
                    if (m_uruns < 65535) m_uruns++;
                    m_mode = (m_mode == 2) ? 1 : 0;
                end else begin
                    if (vld) begin
                        m_slot = (m_slot + 1) % PHASES;
                        if (m_slot == 0 && m_frames < 65535) m_frames++;
                    end
                    if (m_mode == 2) begin
                        if (!en) m_mode = (old_slot == 0 && !phy_ren) ? 0 : 3;
                    end else if (en) begin
                        m_mode = 2;
                    end else if (vld && lst) begin
                        m_mode = 0;
                    end
                end
            end
        endcase
        m_en_prev = en;
    endtask

    // Inputs are set just after a falling edge; this advances one clock and returns at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; phy_ren = 0; empty = 0; level = '0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 0;
    endtask

    task automatic goto_run();
        en = 1; level = 9'(START_THRESH); empty = 0; phy_ren = 0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        #1;
        n_tests++;
        if (dut_vec() !== 45'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), 45'd0);
        end
        do_reset();
        #1;
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_full_rate();
        int pops, flushes, run_idx, bad;
        int fs_pos[$];
        int nopop[$];
        do_reset();
        en = 1; level = 9'd4; empty = 0; phy_ren = 1;
        pops = 0; flushes = 0; run_idx = 0; bad = 0;
        for (int c = 0; c < 68; c++) begin
            #1;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL full_rate_model cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            pops    += int'(o_fifo_ren);
            flushes += int'(o_gb_flush);
            if (o_state == 2'd2) begin
                if (o_frame_start) fs_pos.push_back(run_idx);
                if (!o_fifo_ren) nopop.push_back(run_idx);
                run_idx++;
            end
            step();
        end
        n_tests++;
        if (pops != 64) begin n_fail++; $display("FAIL full_rate_pops got=%0d exp=64", pops); end
        n_tests++;
        if (flushes != 1) begin n_fail++; $display("FAIL full_rate_flush got=%0d exp=1", flushes); end
        if (fs_pos.size() != 2) bad = 1; else if (fs_pos[0] != 0 || fs_pos[1] != 33) bad = 1;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL full_rate_frame_start got_count=%0d exp=2 at slots 0,33", fs_pos.size()); end
        bad = 0;
        if (nopop.size() != 2) bad = 1; else if (nopop[0] != 32 || nopop[1] != 65) bad = 1;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL full_rate_nopop_slots got_count=%0d exp=2 at slots 32,65", nopop.size()); end
`ifdef GB_SCHED_STATS_EN
        n_tests++;
        if (o_frame_cnt !== 16'd2) begin n_fail++; $display("FAIL full_rate_frame_cnt got=%0d exp=2", o_frame_cnt); end
`endif
        // Back at phase 0 with no slot taken: disabling should go straight to IDLE.
        en = 0; phy_ren = 0;
        #1;
        n_tests++;
        if (o_phase !== 6'd0) begin n_fail++; $display("FAIL full_rate_end_phase got=%0d exp=0", o_phase); end
        step();
        #1;
        n_tests++;
        if (o_state !== 2'd0 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL stop_at_phase0 got_state=%0d exp_state=0", o_state);
        end
    endtask

    task automatic test_prime_thresh();
        int pops, not_prime;
        do_reset();
        en = 1; level = 9'd3; empty = 0; phy_ren = 1;
        step();
        pops = 0; not_prime = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL prime_model cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            pops += int'(o_fifo_ren);
            if (o_state !== 2'd1) not_prime++;
            step();
        end
        n_tests++;
        if (pops != 0 || not_prime != 0) begin
            n_fail++; $display("FAIL prime_hold got_pops=%0d got_nonprime=%0d exp=0,0", pops, not_prime);
        end
        level = 9'd4;
        #1;
        n_tests++;
        if (o_state !== 2'd1) begin n_fail++; $display("FAIL prime_level4_same got=%0d exp=1", o_state); end
        step();
        #1;
        n_tests++;
        if (o_state !== 2'd2 || o_phase !== 6'd0) begin
            n_fail++; $display("FAIL prime_enter_run got_state=%0d got_phase=%0d exp=2,0", o_state, o_phase);
        end
    endtask

    task automatic test_toggle();
        int pops, valids;
        do_reset();
        goto_run();
        pops = 0; valids = 0;
        for (int i = 0; i < 66; i++) begin
            phy_ren = (i % 2 == 0);
            #1;
            n_tests++;
            if (o_phase !== 6'(((i + 1) / 2) % PHASES) || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL toggle_phase cyc=%0d got=%0d exp=%0d", i, o_phase, ((i + 1) / 2) % PHASES);
            end
            pops   += int'(o_fifo_ren);
            valids += int'(o_gb_valid);
            step();
        end
        n_tests++;
        if (valids != 33 || pops != 32) begin
            n_fail++; $display("FAIL toggle_counts got_valid=%0d got_pops=%0d exp=33,32", valids, pops);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        goto_run();
        phy_ren = 1; empty = 0;
        repeat (10) step();
        empty = 1;
        #1;
        n_tests++;
        if (o_phase !== 6'd10 || o_fifo_ren !== 1'b0 || o_gb_valid !== 1'b0) begin
            n_fail++; $display("FAIL underrun_slot got_phase=%0d ren=%b valid=%b exp=10,0,0", o_phase, o_fifo_ren, o_gb_valid);
        end
        step();
        empty = 0; phy_ren = 0;
        #1;
        n_tests++;
        if (o_gb_flush !== 1'b1 || o_state !== 2'd1 || o_phase !== 6'd0 || o_underrun !== 1'b1) begin
            n_fail++; $display("FAIL underrun_recover got flush=%b state=%0d phase=%0d urun=%b exp=1,1,0,1",
                               o_gb_flush, o_state, o_phase, o_underrun);
        end
`ifdef GB_SCHED_STATS_EN
        n_tests++;
        if (o_underrun_cnt !== 16'd1) begin n_fail++; $display("FAIL underrun_cnt got=%0d exp=1", o_underrun_cnt); end
`endif
        en = 0;
        step();
        en = 1;
        step();
        #1;
        n_tests++;
        if (o_underrun !== 1'b0 || o_state !== 2'd1 || o_gb_flush !== 1'b1) begin
            n_fail++; $display("FAIL underrun_clear got urun=%b state=%0d flush=%b exp=0,1,1", o_underrun, o_state, o_gb_flush);
        end
    endtask

    task automatic test_stop();
        int pops, slots, cyc;
        bit done;
        do_reset();
        goto_run();
        phy_ren = 1; empty = 0;
        repeat (5) step();
        en = 0;
        pops = 0; slots = 0; done = 0;
        for (cyc = 0; cyc < 60 && !done; cyc++) begin
            #1;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stop_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (cyc == 1 && o_state !== 2'd3) begin
                n_fail++; $display("FAIL stop_state got=%0d exp=3", o_state);
            end
            if (o_state == 2'd0) begin
                done = 1;
            end else begin
                pops += int'(o_fifo_ren);
                if (cyc > 0) slots += int'(o_gb_valid);
                step();
            end
        end
        n_tests++;
        if (!done || pops != 27 || slots != 27 || o_phase !== 6'd0) begin
            n_fail++; $display("FAIL stop_drain got done=%0d pops=%0d slots=%0d phase=%0d exp=1,27,27,0",
                               done, pops, slots, o_phase);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        goto_run();
        phy_ren = 1; empty = 0;
        repeat (20) step();
        #1;
        n_tests++;
        if (o_phase !== 6'd20 || o_fifo_ren !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_pre got_phase=%0d ren=%b exp=20,1", o_phase, o_fifo_ren);
        end
        rst = 1;
        #1;
        n_tests++;
        if (dut_vec() !== 45'd0) begin
            n_fail++; $display("FAIL reset_mid_async got=%h exp=%h", dut_vec(), 45'd0);
        end
        @(negedge clk);
        model_reset();
        rst = 0;
        #1;
        n_tests++;
        if (o_gb_flush !== 1'b0 || o_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_mid_release got flush=%b state=%0d exp=0,0", o_gb_flush, o_state);
        end
        step();
        #1;
        n_tests++;
        if (o_gb_flush !== 1'b1 || o_state !== 2'd1) begin
            n_fail++; $display("FAIL reset_mid_reprime got flush=%b state=%0d exp=1,1", o_gb_flush, o_state);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            phy_ren = ($urandom_range(0, 3) != 0);
            empty   = ($urandom_range(0, 19) == 0);
            level   = 9'($urandom_range(0, 8));
            #1;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_rate();
        test_prime_thresh();
        test_toggle();
        test_underrun();
        test_stop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
